wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter DST_W, default 4, meaning register index width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning write-back queue entries; legal values are powers of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream result valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit can accept a result this cycle.
REQ-008 SHALL have port in_dst, input, DST_W bits: destination register index.
REQ-009 SHALL have port in_alu_res, input, DATA_W bits: ALU result.
REQ-010 SHALL have port in_mem, input, DATA_W bits: raw memory read word.
REQ-011 SHALL have port in_mem_read, input, 1 bit: select memory data (1) or ALU result (0).
REQ-012 SHALL have port in_wb_en, input, 1 bit: the result writes the register file.
REQ-013 SHALL have port in_ld_size, input, 2 bits: load size; 0 = byte, 1 = half, 2 = word(32), 3 = full DATA_W.
REQ-014 SHALL have port in_ld_signed, input, 1 bit: sign-extend (1) or zero-extend (0) the load.
REQ-015 SHALL have port in_addr_lo, input, log2(DATA_W/8) bits: load address low bits.
REQ-016 SHALL have port wb_ready, input, 1 bit: the register file write port is free this cycle.
REQ-017 SHALL have port WB_Dest, output, DST_W bits: write destination.
REQ-018 SHALL have port WB_en_out, output, 1 bit: register file write strobe.
REQ-019 SHALL have port WB_Value, output, DATA_W bits: write data.
REQ-020 SHALL have port q_dst, input, DST_W bits: forwarding query index.
REQ-021 SHALL have port q_hit, output, 1 bit: a pending queued write matches q_dst.
REQ-022 SHALL have port q_value, output, DATA_W bits: value of the youngest matching pending write; 0 when there is no hit.
REQ-023 SHALL have port occupancy, output, log2(DEPTH)+1 bits: number of queued entries.

Function
REQ-024 SHALL accept an input when in_valid & in_ready at a rising edge; in_ready SHALL equal (occupancy != DEPTH), a registered-state function with no dependence on wb_ready.
REQ-025 SHALL discard an accepted input with in_wb_en=0: the handshake completes but nothing is enqueued.
REQ-026 SHALL compute the enqueue value as in_alu_res when in_mem_read=0; otherwise as the extracted load.
REQ-027 SHALL extract loads as follows: byte lane = in_addr_lo; half lane = in_addr_lo >> 1; word lane = in_addr_lo >> 2; full = whole word; the selected lane is then zero- or sign-extended to DATA_W per in_ld_signed.
REQ-028 SHALL treat a size of 3 as identical to 2 when DATA_W = 32.
REQ-029 SHALL have a latency of exactly 1 cycle: an entry accepted at edge N is visible at the head no earlier than the cycle after edge N, with no empty-queue bypass.
REQ-030 SHALL drive WB_en_out = (occupancy != 0) & wb_ready, with WB_Dest and WB_Value equal to the head entry; when the queue is empty, WB_Dest and WB_Value SHALL be 0.
REQ-031 SHALL pop the head at any edge where WB_en_out=1.
REQ-032 SHALL update occupancy as: +1 on enqueue only, -1 on pop only, unchanged on simultaneous enqueue and pop.
REQ-033 SHALL permit simultaneous enqueue and pop when occupancy = DEPTH-1; when full, enqueue SHALL be blocked even if a pop occurs in the same cycle.
REQ-034 SHALL let the read and write pointers wrap modulo DEPTH.
REQ-035 SHALL preserve FIFO order, including for entries with equal destinations.
REQ-036 SHALL compute q_hit and q_value combinationally over valid entries only, with the youngest match winning; index 0 is an ordinary register.

Reset
REQ-037 SHALL, while rst=0 and regardless of clock, set occupancy=0, both pointers=0, all entries invalid, WB_en_out=0, WB_Dest=0, WB_Value=0, q_hit=0 and q_value=0.
REQ-038 SHALL drop all pending entries on reset asserted mid-operation, with no write issued.
REQ-039 SHALL have in_ready=1 at the first edge after reset deasserts.

Structure
REQ-040 SHALL place the load-size encoding constants and the queue-entry typedef (dst, value) in shared package wb_pkg.
REQ-041 SHALL implement load extraction in one combinational sub-module, wb_load_align, parameterised by DATA_W.

Verification
REQ-042 SHALL cover: in_alu_res=0x12345678, dst=3, wb_en=1, mem_read=0, wb_ready=1 -> next cycle WB_en_out=1, WB_Dest=3, WB_Value=0x12345678; following cycle occupancy=0.
REQ-043 SHALL cover: in_mem=0x80FF7F01, byte, addr_lo=1, signed -> WB_Value=0x0000007F; addr_lo=3, signed -> 0xFFFFFF80; half, addr_lo=2, unsigned -> 0x000080FF.
REQ-044 SHALL cover: wb_ready=0 with three back-to-back inputs at DEPTH=2 -> in_ready=0 after two accepts and the third is held; raising wb_ready drains the entries in order, one per cycle.
REQ-045 SHALL cover: queue holds dst=5 (value 0xA) then dst=5 (value 0xB), q_dst=5 -> q_hit=1, q_value=0xB; q_dst=6 -> q_hit=0, q_value=0.
REQ-046 SHALL cover: in_wb_en=0 accepted -> occupancy unchanged and no WB_en_out pulse.
REQ-047 SHALL cover: rst pulled low with 2 entries queued, mid-cycle -> all outputs 0 immediately, no write after release, in_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back definitions: load-size encodings and the queue entry layout.
// Entry fields are sized for the widest supported configuration; the unit uses the low bits.
package wb_pkg;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;
    localparam logic [1:0] LD_FULL = 2'd3;

    localparam int WB_DST_MAX  = 8;
    localparam int WB_DATA_MAX = 64;

    typedef struct packed {
        logic [WB_DST_MAX-1:0]  dst;
        logic [WB_DATA_MAX-1:0] value;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load lane extraction: picks the byte/half/word lane addressed by addr_lo and extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            mem,
    input  logic [$clog2(DATA_W/8)-1:0]  addr_lo,
    input  logic [1:0]                   size,
    input  logic                         sgn,
    output logic [DATA_W-1:0]            ld_out
);

    localparam int AW = $clog2(DATA_W/8);
    // Lane bit offsets: half/word offsets are the byte offset rounded down to their alignment.
    localparam logic [AW+2:0] H_MASK = ~(AW+3)'(15);
    localparam logic [AW+2:0] W_MASK = ~(AW+3)'(31);

    logic [AW+2:0] b_sh, h_sh, w_sh;
    logic [7:0]    b_lane;
    logic [15:0]   h_lane;
    logic [31:0]   w_lane;

    always_comb begin
        b_sh   = {addr_lo, 3'b000};
        h_sh   = b_sh & H_MASK;
        w_sh   = b_sh & W_MASK;
        b_lane = mem[b_sh +: 8];
        h_lane = mem[h_sh +: 16];
        w_lane = mem[w_sh +: 32];
    end

    always_comb begin
        ld_out = mem;
        case (size)
            LD_BYTE: ld_out = sgn ? DATA_W'($signed(b_lane)) : DATA_W'(b_lane);
            LD_HALF: ld_out = sgn ? DATA_W'($signed(h_lane)) : DATA_W'(h_lane);
            LD_WORD: ld_out = sgn ? DATA_W'($signed(w_lane)) : DATA_W'(w_lane);
            // At 32 bits the word lane already is the whole word, so full == word.
            default: ld_out = mem;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Write-back unit: selects ALU or aligned load data, queues register writes in a small FIFO,
// drains one per cycle when the register file port is free, and answers forwarding queries.
module wb_unit
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DST_W  = 4,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DST_W-1:0]             in_dst,
    input  logic [DATA_W-1:0]            in_alu_res,
    input  logic [DATA_W-1:0]            in_mem,
    input  logic                         in_mem_read,
    input  logic                         in_wb_en,
    input  logic [1:0]                   in_ld_size,
    input  logic                         in_ld_signed,
    input  logic [$clog2(DATA_W/8)-1:0]  in_addr_lo,
    input  logic                         wb_ready,
    output logic [DST_W-1:0]             WB_Dest,
    output logic                         WB_en_out,
    output logic [DATA_W-1:0]            WB_Value,
    input  logic [DST_W-1:0]             q_dst,
    output logic                         q_hit,
    output logic [DATA_W-1:0]            q_value,
    output logic [$clog2(DEPTH):0]       occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]            occ_q, occ_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    wb_entry_t [DEPTH-1:0]  ent_q, ent_d;

    wb_entry_t              head, enq_ent;
    logic [DATA_W-1:0]      ld_val;
    logic                   push, pop, empty;
    logic [PW-1:0]          idx;
    logic                   unused_ok;

    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .mem     (in_mem),
        .addr_lo (in_addr_lo),
        .size    (in_ld_size),
        .sgn     (in_ld_signed),
        .ld_out  (ld_val)
    );

    // Upper struct bits are always zero in narrower configurations.
    assign unused_ok = ^ent_q;

    always_comb begin
        empty     = (occ_q == '0);
        in_ready  = (occ_q != FULL);
        head      = ent_q[rd_ptr_q];
        WB_en_out = ~empty & wb_ready;
        WB_Dest   = empty ? '0 : head.dst[DST_W-1:0];
        WB_Value  = empty ? '0 : head.value[DATA_W-1:0];
        occupancy = occ_q;
        push      = in_valid & in_ready & in_wb_en;
        pop       = WB_en_out;
        enq_ent.dst   = WB_DST_MAX'(in_dst);
        enq_ent.value = WB_DATA_MAX'(in_mem_read ? ld_val : in_alu_res);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        vld_d    = vld_q;
        ent_d    = ent_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        if (pop) vld_d[rd_ptr_q] = 1'b0;
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            ent_d[wr_ptr_q] = enq_ent;
        end
    end

    // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
    always_comb begin
        q_hit   = 1'b0;
        q_value = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (vld_q[idx] && ent_q[idx].dst == WB_DST_MAX'(q_dst)) begin
                q_hit   = 1'b1;
                q_value = ent_q[idx].value[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            vld_q    <= '0;
            ent_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            vld_q    <= vld_d;
            ent_q    <= ent_d;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit at DATA_W=32, DST_W=4, DEPTH=2 with hand-computed expectations.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mem_read, in_wb_en, in_ld_signed, wb_ready;
    logic [3:0]  in_dst, WB_Dest, q_dst;
    logic [31:0] in_alu_res, in_mem, WB_Value, q_value;
    logic [1:0]  in_ld_size, in_addr_lo, occupancy;
    logic        WB_en_out, q_hit;

    int n_chk  = 0;
    int n_pass = 0;

    wb_unit #(.DATA_W(32), .DST_W(4), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dst(in_dst),
        .in_alu_res(in_alu_res), .in_mem(in_mem), .in_mem_read(in_mem_read), .in_wb_en(in_wb_en),
        .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed), .in_addr_lo(in_addr_lo),
        .wb_ready(wb_ready), .WB_Dest(WB_Dest), .WB_en_out(WB_en_out), .WB_Value(WB_Value),
        .q_dst(q_dst), .q_hit(q_hit), .q_value(q_value), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] d, input logic [31:0] v);
        in_valid = 1'b1; in_wb_en = 1'b1; in_mem_read = 1'b0; in_dst = d; in_alu_res = v;
    endtask

    task automatic ld(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [1:0] a, input logic [31:0] exp);
        in_valid = 1'b1; in_wb_en = 1'b1; in_mem_read = 1'b1; in_dst = 4'd9;
        in_alu_res = 32'hDEADBEEF; in_mem = 32'h80FF7F01;
        in_ld_size = sz; in_ld_signed = sg; in_addr_lo = a; wb_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_en"}, WB_en_out, 1);
        chk(tag, WB_Value, exp);
        tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 0; in_dst = 0; in_alu_res = 0; in_mem = 0; in_mem_read = 0;
        in_wb_en = 0; in_ld_size = 0; in_ld_signed = 0; in_addr_lo = 0; wb_ready = 0; q_dst = 0;
        #1;
        chk("rst_occ", occupancy, 0);
        chk("rst_en", WB_en_out, 0);
        chk("rst_dest", WB_Dest, 0);
        chk("rst_val", WB_Value, 0);
        chk("rst_qhit", q_hit, 0);
        chk("rst_qval", q_value, 0);
        #11 rst = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);

        // Basic ALU write, 1-cycle latency, no bypass
        enq(4'd3, 32'h12345678); wb_ready = 1'b1;
        #0 chk("nobypass_en", WB_en_out, 0);
        tick();
        in_valid = 1'b0;
        chk("alu_en", WB_en_out, 1);
        chk("alu_dest", WB_Dest, 3);
        chk("alu_val", WB_Value, 32'h12345678);
        chk("alu_occ1", occupancy, 1);
        tick();
        chk("alu_occ0", occupancy, 0);
        chk("alu_en0", WB_en_out, 0);

        // Load extraction from 0x80FF7F01
        ld("ld_b1s", 2'd0, 1'b1, 2'd1, 32'h0000007F);
        ld("ld_b3s", 2'd0, 1'b1, 2'd3, 32'hFFFFFF80);
        ld("ld_h2u", 2'd1, 1'b0, 2'd2, 32'h000080FF);
        ld("ld_h2s", 2'd1, 1'b1, 2'd2, 32'hFFFF80FF);
        ld("ld_b2u", 2'd0, 1'b0, 2'd2, 32'h000000FF);
        ld("ld_h0s", 2'd1, 1'b1, 2'd1, 32'h00007F01);
        ld("ld_w", 2'd2, 1'b1, 2'd3, 32'h80FF7F01);
        ld("ld_full", 2'd3, 1'b0, 2'd1, 32'h80FF7F01);

        // Backpressure: fill, block third, drain in order
        wb_ready = 1'b0;
        enq(4'd1, 32'h11); tick();
        chk("bp_occ1", occupancy, 1);
        chk("bp_rdy1", in_ready, 1);
        enq(4'd2, 32'h22); tick();
        chk("bp_occ2", occupancy, 2);
        chk("bp_rdy2", in_ready, 0);
        enq(4'd7, 32'h33); tick();
        chk("bp_held_occ", occupancy, 2);
        chk("bp_held_en", WB_en_out, 0);
        chk("bp_head_val", WB_Value, 32'h11);
        wb_ready = 1'b1;
        #0 chk("bp_drain1_dest", WB_Dest, 1);
        tick();
        chk("bp_full_block_occ", occupancy, 1);
        chk("bp_drain2_dest", WB_Dest, 2);
        chk("bp_drain2_val", WB_Value, 32'h22);
        chk("bp_rdy3", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_simul_occ", occupancy, 1);
        chk("bp_drain3_dest", WB_Dest, 7);
        chk("bp_drain3_val", WB_Value, 32'h33);
        tick();
        chk("bp_empty", occupancy, 0);

        // Forwarding: youngest of equal destinations wins
        wb_ready = 1'b0; q_dst = 4'd5;
        enq(4'd5, 32'hA); tick();
        chk("fw_one", q_value, 32'hA);
        enq(4'd5, 32'hB); tick();
        in_valid = 1'b0;
        chk("fw_hit", q_hit, 1);
        chk("fw_young", q_value, 32'hB);
        q_dst = 4'd6;
        #0;
        chk("fw_miss", q_hit, 0);
        chk("fw_miss_val", q_value, 0);
        wb_ready = 1'b1;
        tick();
        chk("fw_order_dest", WB_Dest, 5);
        chk("fw_order_val", WB_Value, 32'hB);
        tick();
        chk("fw_empty", occupancy, 0);

        // Discarded result: handshake but no enqueue
        in_valid = 1'b1; in_wb_en = 1'b0; in_mem_read = 1'b0; in_dst = 4'd4; in_alu_res = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        chk("nowb_occ", occupancy, 0);
        chk("nowb_en", WB_en_out, 0);

        // Register 0 is ordinary; then fill for the reset test
        wb_ready = 1'b0; q_dst = 4'd0;
        enq(4'd0, 32'h55); tick();
        chk("r0_hit", q_hit, 1);
        chk("r0_val", q_value, 32'h55);
        enq(4'd2, 32'h66); tick();
        in_valid = 1'b0;
        chk("pre_rst_occ", occupancy, 2);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b0; wb_ready = 1'b1;
        #1;
        chk("arst_occ", occupancy, 0);
        chk("arst_en", WB_en_out, 0);
        chk("arst_dest", WB_Dest, 0);
        chk("arst_val", WB_Value, 0);
        chk("arst_qhit", q_hit, 0);
        chk("arst_qval", q_value, 0);
        tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_rdy", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_en", WB_en_out, 0);
            chk("post_rst_occ", occupancy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
